// File: rtl/tc_pkg.sv
// tc_pkg: shared bank-state encoding and helpers for the partial-sum accumulator (sat_add is used when TC_PSUM_SAT_EN is defined)
package tc_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FILL   = 2'd1,
        CLOSED = 2'd2,
        DRAIN  = 2'd3
    } bank_state_t;

    function automatic int clog2_min1(input int v);
        return v > 1 ? $clog2(v) : 1;
    endfunction

    // Operands arrive sign-extended to 64 bits, so the raw sum cannot overflow for w <= 63.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
        logic signed [63:0] s, hi, lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return s > hi ? hi : s < lo ? lo : s;
    endfunction

endpackage

// File: rtl/tc_psum_bank.sv
// tc_psum_bank: one M x N accumulator bank with tile accumulate, row read and row zero (saturating add under TC_PSUM_SAT_EN)
module tc_psum_bank import tc_pkg::*; #(
    parameter int M       = 16,
    parameter int N       = 16,
    parameter int TILE_M  = 4,
    parameter int TILE_N  = 4,
    parameter int DW_DATA = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr,
    input  logic [clog2_min1(M/TILE_M)-1:0]     tile_row,
    input  logic [clog2_min1(N/TILE_N)-1:0]     tile_col,
    input  logic [TILE_M*TILE_N*DW_DATA-1:0]    tile_data,
    input  logic [clog2_min1(M)-1:0]            rd_row,
    input  logic                                clr,
    output logic [N*DW_DATA-1:0]                rd_data
);

    localparam int TRW = clog2_min1(M / TILE_M);
    localparam int TCW = clog2_min1(N / TILE_N);
    localparam int RW  = clog2_min1(M);

    logic [DW_DATA-1:0] mem [M][N];

    function automatic logic [DW_DATA-1:0] acc(input logic [DW_DATA-1:0] a, input logic [DW_DATA-1:0] b);
`ifdef TC_PSUM_SAT_EN
        return DW_DATA'(sat_add(64'($signed(a)), 64'($signed(b)), DW_DATA));
`else
        return a + b;
`endif
    endfunction

    // Each element clears when its row is handed off, otherwise adds its slot of an incoming tile.
    always_ff @(posedge clk)
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                if (!rst)
                    mem[r][c] <= '0;
                else if (clr && rd_row == RW'(r))
                    mem[r][c] <= '0;
                else if (wr && tile_row == TRW'(r / TILE_M) && tile_col == TCW'(c / TILE_N))
                    mem[r][c] <= acc(mem[r][c], tile_data[((r % TILE_M) * TILE_N + c % TILE_N) * DW_DATA +: DW_DATA]);

    for (genvar c = 0; c < N; c++) begin : g_rd
        assign rd_data[c*DW_DATA +: DW_DATA] = mem[rd_row][c];
    end

endmodule

// File: rtl/tc_psum_acc.sv
// tc_psum_acc: double-buffered partial-sum accumulator; one bank fills while the other drains (TC_PSUM_SAT_EN selects saturating adds)
module tc_psum_acc import tc_pkg::*; #(
    parameter int M       = 16,
    parameter int N       = 16,
    parameter int TILE_M  = 4,
    parameter int TILE_N  = 4,
    parameter int DW_DATA = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [clog2_min1(M/TILE_M)-1:0]     in_row,
    input  logic [clog2_min1(N/TILE_N)-1:0]     in_col,
    input  logic                                in_last,
    input  logic [TILE_M*TILE_N*DW_DATA-1:0]    in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [clog2_min1(M)-1:0]            out_row,
    output logic                                out_last,
    output logic [N*DW_DATA-1:0]                out_data,
    output logic                                busy
);

    localparam int RW = clog2_min1(M);

    bank_state_t       st  [2];
    bank_state_t       nst [2];
    logic              wr_bank, rd_bank, nwr, nrd;
    logic [RW-1:0]     cnt, ncnt;
    logic [N*DW_DATA-1:0] rd_data [2];
    logic              in_hs, out_hs;

    assign in_ready  = st[wr_bank] == EMPTY || st[wr_bank] == FILL;
    assign out_valid = st[rd_bank] == DRAIN;
    assign out_row   = cnt;
    assign out_last  = out_valid && cnt == RW'(M - 1);
    assign out_data  = rd_data[rd_bank];
    assign busy      = st[0] != EMPTY || st[1] != EMPTY;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        tc_psum_bank #(
            .M(M), .N(N), .TILE_M(TILE_M), .TILE_N(TILE_N), .DW_DATA(DW_DATA)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .wr        (in_hs && wr_bank == 1'(b)),
            .tile_row  (in_row),
            .tile_col  (in_col),
            .tile_data (in_data),
            .rd_row    (cnt),
            .clr       (out_hs && rd_bank == 1'(b)),
            .rd_data   (rd_data[b])
        );
    end

    // Bank states, pointers and drain row counter.
    always_ff @(posedge clk)
        if (!rst) begin
            st      <= '{EMPTY, EMPTY};
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            cnt     <= '0;
        end else begin
            st      <= nst;
            wr_bank <= nwr;
            rd_bank <= nrd;
            cnt     <= ncnt;
        end

    // Fill/close on the input side, free on the final row; a closed bank under rd_bank starts draining at once.
    always_comb begin
        nst  = st;
        nwr  = wr_bank;
        nrd  = rd_bank;
        ncnt = cnt;
        if (in_hs) begin
            nst[wr_bank] = in_last ? CLOSED : FILL;
            nwr          = wr_bank ^ in_last;
        end
        if (out_hs) begin
            ncnt = out_last ? '0 : cnt + 1'b1;
            if (out_last) begin
                nst[rd_bank] = EMPTY;
                nrd          = ~rd_bank;
            end
        end
        if (nst[nrd] == CLOSED)
            nst[nrd] = DRAIN;
    end

endmodule

// File: tb/tb_tc_psum_acc.sv
// tb_tc_psum_acc: randomized self-checking bench for tc_psum_acc against a block-queue reference model
module tb_tc_psum_acc;
    import tc_pkg::*;

    localparam int M = 16, N = 16, TM = 4, TN = 4, DW = 32;
    localparam int TRW = clog2_min1(M / TM);
    localparam int TCW = clog2_min1(N / TN);
    localparam int RW  = clog2_min1(M);
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -MAXV - 64'sd1;

    typedef int blk_t [M][N];

    logic clk = 1'b0, rst = 1'b0;
    logic in_valid = 1'b0, in_ready, in_last = 1'b0;
    logic [TRW-1:0] in_row = '0;
    logic [TCW-1:0] in_col = '0;
    logic [TM*TN*DW-1:0] in_data = '0;
    logic out_valid, out_ready = 1'b0, out_last, busy;
    logic [RW-1:0] out_row;
    logic [N*DW-1:0] out_data;

    int n_tests = 0, n_fail = 0;
    blk_t q[$];
    blk_t blk;
    bit filling = 0;
    int drow = 0;
    bit ordy = 0;
    int tile [TM*TN];

    always #5 clk = ~clk;

    tc_psum_acc #(.M(M), .N(N), .TILE_M(TM), .TILE_N(TN), .DW_DATA(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row), .in_col(in_col),
        .in_last(in_last), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_last(out_last), .out_data(out_data), .busy(busy)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int add(input int a, input int b);
        longint s = longint'(a) + longint'(b);
`ifdef TC_PSUM_SAT_EN
        if (s > MAXV) s = MAXV;
        if (s < MINV) s = MINV;
`endif
        return int'(s);
    endfunction

    function automatic void fill(input int v);
        foreach (tile[k]) tile[k] = v;
    endfunction

    // One cycle: check outputs against the model, drive inputs, advance the model across the edge.
    task automatic step(input bit iv, input int r, input int c, input bit l, input bit rs);
        logic [N*DW-1:0] er;
        bit ih, oh;
        check("in_ready", in_ready, q.size() < 2);
        check("out_valid", out_valid, q.size() > 0);
        check("busy", busy, q.size() > 0 || filling);
        if (q.size() > 0) begin
            for (int j = 0; j < N; j++) er[j*DW +: DW] = q[0][drow][j];
            check("out_row", out_row, drow);
            check("out_last", out_last, drow == M - 1);
            check("out_data", out_data, er);
        end
        rst = rs;
        in_valid = iv;
        in_row = TRW'(r);
        in_col = TCW'(c);
        in_last = l;
        for (int k = 0; k < TM * TN; k++) in_data[k*DW +: DW] = tile[k];
        out_ready = ordy;
        ih = rs && iv && q.size() < 2;
        oh = rs && ordy && q.size() > 0;
        @(posedge clk);
        if (!rs) begin
            q.delete();
            blk = '{default: 0};
            filling = 0;
            drow = 0;
        end
        if (oh) begin
            drow++;
            if (drow == M) begin
                q.delete(0);
                drow = 0;
            end
        end
        if (ih) begin
            for (int i = 0; i < TM; i++)
                for (int j = 0; j < TN; j++)
                    blk[r*TM+i][c*TN+j] = add(blk[r*TM+i][c*TN+j], tile[i*TN+j]);
            filling = 1;
            if (l) begin
                q.push_back(blk);
                blk = '{default: 0};
                filling = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 1);
    endtask

    initial begin
        blk = '{default: 0};
        fill(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_row", out_row, 0);
        check("rst_out_last", out_last, 0);
        idle(1);
        rst = 1'b1;

        // single block of all-ones tiles, last on (3,3)
        ordy = 1;
        fill(1);
        for (int t = 0; t < 16; t++) step(1, t / 4, t % 4, t == 15, 1);
        fill(0);
        idle(20);

        // same tile three back-to-back values, closed with a zero tile
        fill(5);  step(1, 1, 2, 0, 1);
        fill(7);  step(1, 1, 2, 0, 1);
        fill(-2); step(1, 1, 2, 0, 1);
        fill(0);  step(1, 0, 0, 1, 1);
        idle(20);

        // two blocks while the drain is stalled, then release
        ordy = 0;
        foreach (tile[k]) tile[k] = int'($urandom);
        step(1, 0, 0, 0, 1);
        step(1, 3, 3, 1, 1);
        foreach (tile[k]) tile[k] = int'($urandom);
        step(1, 2, 1, 0, 1);
        step(1, 1, 3, 1, 1);
        for (int k = 0; k < 3; k++) step(1, 1, 1, 0, 1);
        ordy = 1;
        idle(40);

        // overflow edges at one coordinate each
        fill(int'(32'h7fffffff)); step(1, 0, 0, 0, 1);
        fill(100);                step(1, 0, 0, 0, 1);
        fill(int'(32'h80000000)); step(1, 3, 0, 0, 1);
        fill(-5);                 step(1, 3, 0, 1, 1);
        fill(0);
        idle(20);

        // random traffic with random drain backpressure
        for (int k = 0; k < 400; k++) begin
            foreach (tile[x]) tile[x] = int'($urandom);
            ordy = $urandom_range(0, 2) != 0;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 9) == 0, 1);
        end
        ordy = 1;
        fill(0);
        idle(40);

        // reset in the middle of a drain
        fill(9);
        step(1, 2, 2, 1, 1);
        for (int k = 0; k < 40 && !(q.size() > 0 && drow == 7); k++) idle(1);
        check("reached_row7", drow, 7);
        step(0, 0, 0, 0, 0);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_out_row", out_row, 0);
        fill(3);
        step(1, 2, 1, 1, 1);
        fill(0);
        idle(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
